keypad_scan_display: RTL and testbench
======================================

// Module: keypad_scan_display
// PURPOSE
//  Debounced 4x4 hex keypad scanner with an N-digit multiplexed seven-segment display.
//  Scans columns, debounces each press and release, and emits one key event per press
//  over a valid/ready port. Each accepted key also shifts into a digit history shown
//  right-aligned on the display. Sits between keypad/display pads and the system core.
// PARAMETERS
//  SCANBITS     3   column dwell = 2^SCANBITS clk cycles; legal range is 2 or more
//  DEBOUNCE     8   consecutive stable cycles needed to confirm a press or a release; 1..255
//  NDIGITS      2   display digits and history depth; 1..8
//  REFRESHBITS  4   each digit is lit for 2^REFRESHBITS cycles
// PORTS
//  clk          in   1          single clock, rising edge
//  reset_n      in   1          synchronous, active-low reset
//  rows         in   4          keypad rows, active-high, asynchronous; rows[3] is the top row
//  cols         out  4          one-hot column drive; top level uses it as data and pad enable
//  key_valid    out  1          key event available
//  key_ready    in   1          consumer accepts the event when key_valid & key_ready
//  key_code     out  4          hex code of the event
//  key_overflow out  1          sticky: a press was dropped because the event buffer was full
//  digit_en     out  NDIGITS    one-hot active-high digit enable; bit 0 is the rightmost digit
//  seg          out  7          {g..a}, active-low (common anode)
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge), applied to all state including mid-debounce:
//   - FSM=SCAN, column index 0, cols=4'b1000
//   - key_valid=0, key_code=0, key_overflow=0
//   - history cleared, filled count=0
//   - digit_en=1 (bit 0), seg=7'h7F
//  rows pass through a 2-flop synchronizer (rows_s). Input-to-FSM latency is 2 cycles.
//  Column c drives cols = 4'b1000 >> c.
//  Key map, by column, for rows top..bottom:
//   - c0: 1 4 7 E
//   - c1: 2 5 8 0
//   - c2: 3 6 9 F
//   - c3: A B C D
//  When several rows are high, the highest row bit wins.
//  FSM states:
//   - SCAN: the dwell counter runs. At the end of the dwell, if rows_s==0, advance c (3 wraps to 0).
//     Otherwise capture the winning row as a one-hot hit mask, clear the counter and go to PRESS_DB.
//   - PRESS_DB: if rows_s&hit is set, count up. When count reaches DEBOUNCE-1, accept the key and
//     go to HELD. If the bit drops, go to SCAN with c unchanged. The column is frozen.
//   - HELD: stay while rows_s&hit is set. When it clears, zero the counter and go to REL_DB.
//     Presses on other rows or columns are ignored.
//   - REL_DB: count cycles with rows_s&hit clear. At DEBOUNCE-1, go to SCAN and advance c.
//     If the bit reappears, go back to HELD and generate no new event.
//  On key accept:
//   - history shifts left and the new code enters digit 0.
//   - filled count saturates at NDIGITS.
//   - If key_valid=0, or key_valid & key_ready in the same cycle: load key_code and set key_valid
//     on the next edge.
//   - Otherwise the event is dropped, key_code is unchanged and key_overflow is set.
//  Handshake:
//   - key_valid stays high and key_code stays stable until accepted.
//   - key_valid falls the cycle after a handshake unless it is reloaded at the same edge.
//   - key_ready while key_valid=0 has no effect.
//   - key_overflow clears only on reset.
//  Display:
//   - A refresh counter rotates digit_en through bits 0..NDIGITS-1, then wraps.
//   - seg shows hex-to-seg of history[i] for the active digit i.
//   - seg=7'h7F for i >= filled count, so leading blanks appear.
//   - Digit 0 shows 0 -> 7'h40, 1 -> 7'h79, A -> 7'h08, F -> 7'h0E.
//  Sizing and rules:
//   - Counters are sized $clog2 of their limit.
//   - No combinational path from rows to any output.
//   - cols and digit_en are registered.
// STRUCTURE
//  Package keypad_pkg:
//   - scan_state_t enum {SCAN, PRESS_DB, HELD, REL_DB}
//   - function key_map(col, rowhit) -> 4-bit code
//   - function hex_to_seg(4-bit) -> 7-bit active-low
//   - localparam SEG_BLANK = 7'h7F
//  Sub-module seg_mux_display (NDIGITS, REFRESHBITS):
//   - inputs: history, filled count
//   - outputs: digit_en, seg
//   - owns the refresh counter
//  The top holds the synchronizer, FSM, counters, event buffer and history.
// TESTING
//  1. Reset, idle 64 cycles, rows=0 -> cols cycles 1000,0100,0010,0001 every 8 cycles; key_valid=0; seg=7F.
//  2. Hold rows=4'b0100 while cols=0100 for 20 cycles, key_ready=1 -> exactly 1 event, key_code=5.
//     Digit 0 shows 7'h12; cols stays frozen until release + 8 stable cycles.
//  3. Bounce: rows toggles every 3 cycles for 30 cycles on col3/top row -> no event.
//     Then stable -> one event with code A.
//  4. key_ready=0, press 3 then 9 -> key_valid=1, key_code=3, key_overflow=1.
//     History shows "39" with NDIGITS=2; after key_ready=1 for 1 cycle, key_valid=0.
//  5. Release glitch: 3 cycles low inside REL_DB, then high -> back to HELD, no second event.
//  6. Assert reset_n=0 mid PRESS_DB -> all outputs at reset values the next cycle; no event after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helper functions for the keypad scanner and display.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        REL_DB
    } scan_state_t;

    // All segments off (active-low outputs).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex code for a column index and a one-hot row hit; rowhit[3] is the top row.
    function automatic logic [3:0] key_map(input logic [1:0] col, input logic [3:0] rowhit);
        logic [1:0] r;
        logic [3:0] code;
        // Row index counted from the top; the highest set bit wins.
        if (rowhit[3])      r = 2'd0;
        else if (rowhit[2]) r = 2'd1;
        else if (rowhit[1]) r = 2'd2;
        else                r = 2'd3;
        code = 4'h0;
        case (col)
            2'd0: case (r)
                2'd0: code = 4'h1;
                2'd1: code = 4'h4;
                2'd2: code = 4'h7;
                default: code = 4'hE;
            endcase
            2'd1: case (r)
                2'd0: code = 4'h2;
                2'd1: code = 4'h5;
                2'd2: code = 4'h8;
                default: code = 4'h0;
            endcase
            2'd2: case (r)
                2'd0: code = 4'h3;
                2'd1: code = 4'h6;
                2'd2: code = 4'h9;
                default: code = 4'hF;
            endcase
            default: case (r)
                2'd0: code = 4'hA;
                2'd1: code = 4'hB;
                2'd2: code = 4'hC;
                default: code = 4'hD;
            endcase
        endcase
        return code;
    endfunction

    // Hex digit to {g..a} segments, active-low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] s;
        case (value)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_mux_display.sv
// Multiplexed seven-segment driver: rotates one active digit and shows its history entry.
module seg_mux_display
    import keypad_pkg::*;
#(
    parameter int NDIGITS     = 2,
    parameter int REFRESHBITS = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NDIGITS-1:0][3:0]          history,
    input  logic [$clog2(NDIGITS+1)-1:0]     filled,
    output logic [NDIGITS-1:0]               digit_en,
    output logic [6:0]                       seg
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic [REFRESHBITS-1:0] refresh_reg;
    logic [REFRESHBITS-1:0] refresh_next;
    logic [IW-1:0]          idx_reg;
    logic [IW-1:0]          idx_next;
    logic [6:0]             seg_next;
    logic [NDIGITS-1:0]     digit_en_reg;
    logic [6:0]             seg_reg;

    // Advance the digit index at the end of each refresh period; blank digits not yet filled.
    always_comb begin
        refresh_next = refresh_reg + REFRESHBITS'(1);
        idx_next     = idx_reg;
        if (refresh_reg == '1) begin
            idx_next = (idx_reg == IW'(NDIGITS - 1)) ? '0 : idx_reg + IW'(1);
        end
        if (int'(idx_next) < int'(filled)) begin
            seg_next = hex_to_seg(history[idx_next]);
        end else begin
            seg_next = SEG_BLANK;
        end
    end

    // Register the refresh counter, digit enable and segments together so they stay aligned.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            refresh_reg  <= '0;
            idx_reg      <= '0;
            digit_en_reg <= NDIGITS'(1);
            seg_reg      <= SEG_BLANK;
        end else begin
            refresh_reg  <= refresh_next;
            idx_reg      <= idx_next;
            digit_en_reg <= NDIGITS'(1) << idx_next;
            seg_reg      <= seg_next;
        end
    end

    assign digit_en = digit_en_reg;
    assign seg      = seg_reg;

endmodule

// File: rtl/keypad_scan_display.sv
// Debounced 4x4 keypad scanner with a key event port and a digit history display.
module keypad_scan_display
    import keypad_pkg::*;
#(
    parameter int SCANBITS    = 3,
    parameter int DEBOUNCE    = 8,
    parameter int NDIGITS     = 2,
    parameter int REFRESHBITS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         rows,
    output logic [3:0]         cols,
    output logic               key_valid,
    input  logic               key_ready,
    output logic [3:0]         key_code,
    output logic               key_overflow,
    output logic [NDIGITS-1:0] digit_en,
    output logic [6:0]         seg
);

    localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int FW  = $clog2(NDIGITS + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);

    logic [3:0]              rows_meta_reg;
    logic [3:0]              rows_s_reg;
    scan_state_t             state_reg, state_next;
    logic [SCANBITS-1:0]     dwell_reg, dwell_next;
    logic [DBW-1:0]          db_reg, db_next;
    logic [1:0]              col_reg, col_next;
    logic [3:0]              hit_reg, hit_next;
    logic [3:0]              cols_reg;
    logic [3:0]              win_hit;
    logic                    hit_on;
    logic                    accept;
    logic [3:0]              accept_code;
    logic                    key_valid_reg;
    logic [3:0]              key_code_reg;
    logic                    key_overflow_reg;
    logic [NDIGITS-1:0][3:0] history_reg;
    logic [NDIGITS-1:0][3:0] history_shift;
    logic [FW-1:0]           filled_reg;

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rows_meta_reg <= '0;
            rows_s_reg    <= '0;
        end else begin
            rows_meta_reg <= rows;
            rows_s_reg    <= rows_meta_reg;
        end
    end

    // Pick the highest active row as a one-hot hit.
    always_comb begin
        win_hit = 4'b0000;
        if (rows_s_reg[3])      win_hit = 4'b1000;
        else if (rows_s_reg[2]) win_hit = 4'b0100;
        else if (rows_s_reg[1]) win_hit = 4'b0010;
        else if (rows_s_reg[0]) win_hit = 4'b0001;
    end

    assign hit_on      = |(rows_s_reg & hit_reg);
    assign accept_code = key_map(col_reg, hit_reg);

    // Scan/debounce next-state logic; the column only moves in SCAN or after a confirmed release.
    always_comb begin
        state_next = state_reg;
        dwell_next = dwell_reg;
        db_next    = db_reg;
        col_next   = col_reg;
        hit_next   = hit_reg;
        accept     = 1'b0;
        case (state_reg)
            SCAN: begin
                dwell_next = dwell_reg + SCANBITS'(1);
                if (dwell_reg == '1) begin
                    if (rows_s_reg == 4'b0000) begin
                        col_next = col_reg + 2'd1;
                    end else begin
                        hit_next   = win_hit;
                        dwell_next = '0;
                        db_next    = '0;
                        state_next = PRESS_DB;
                    end
                end
            end
            PRESS_DB: begin
                if (hit_on) begin
                    if (db_reg == DB_LAST) begin
                        accept     = 1'b1;
                        state_next = HELD;
                    end else begin
                        db_next = db_reg + DBW'(1);
                    end
                end else begin
                    state_next = SCAN;
                end
            end
            HELD: begin
                if (!hit_on) begin
                    db_next    = '0;
                    state_next = REL_DB;
                end
            end
            REL_DB: begin
                if (hit_on) begin
                    state_next = HELD;
                end else if (db_reg == DB_LAST) begin
                    col_next   = col_reg + 2'd1;
                    state_next = SCAN;
                end else begin
                    db_next = db_reg + DBW'(1);
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // Scanner state, counters and the registered column drive.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= SCAN;
            dwell_reg <= '0;
            db_reg    <= '0;
            col_reg   <= 2'd0;
            hit_reg   <= 4'b0000;
            cols_reg  <= 4'b1000;
        end else begin
            state_reg <= state_next;
            dwell_reg <= dwell_next;
            db_reg    <= db_next;
            col_reg   <= col_next;
            hit_reg   <= hit_next;
            cols_reg  <= 4'b1000 >> col_next;
        end
    end

    // Single-entry event buffer: a new key loads only if the slot is free or being drained now.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_valid_reg    <= 1'b0;
            key_code_reg     <= 4'h0;
            key_overflow_reg <= 1'b0;
        end else if (accept) begin
            if (!key_valid_reg || key_ready) begin
                key_valid_reg <= 1'b1;
                key_code_reg  <= accept_code;
            end else begin
                key_overflow_reg <= 1'b1;
            end
        end else if (key_valid_reg && key_ready) begin
            key_valid_reg <= 1'b0;
        end
    end

    // History shifts toward higher digits; the newest key lands in digit 0.
    assign history_shift[0] = accept_code;
    for (genvar gi = 1; gi < NDIGITS; gi++) begin : g_shift
        assign history_shift[gi] = history_reg[gi-1];
    end

    // Digit history and saturating fill count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            history_reg <= '0;
            filled_reg  <= '0;
        end else if (accept) begin
            history_reg <= history_shift;
            if (filled_reg != FW'(NDIGITS)) begin
                filled_reg <= filled_reg + FW'(1);
            end
        end
    end

    seg_mux_display #(
        .NDIGITS    (NDIGITS),
        .REFRESHBITS(REFRESHBITS)
    ) u_display (
        .clk     (clk),
        .reset_n (reset_n),
        .history (history_reg),
        .filled  (filled_reg),
        .digit_en(digit_en),
        .seg     (seg)
    );

    assign cols         = cols_reg;
    assign key_valid    = key_valid_reg;
    assign key_code     = key_code_reg;
    assign key_overflow = key_overflow_reg;

endmodule

// File: tb/tb_keypad_scan_display.sv
// Self-checking bench: physical keypad model, event scoreboard and display history model.
module tb_keypad_scan_display;

    localparam int NDIGITS = 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [3:0]         rows;
    logic [3:0]         cols;
    logic               key_valid;
    logic               key_ready = 1'b0;
    logic [3:0]         key_code;
    logic               key_overflow;
    logic [NDIGITS-1:0] digit_en;
    logic [6:0]         seg;

    keypad_scan_display #(
        .SCANBITS(3), .DEBOUNCE(8), .NDIGITS(NDIGITS), .REFRESHBITS(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rows(rows), .cols(cols),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_overflow(key_overflow), .digit_en(digit_en), .seg(seg)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    logic [3:0] evq[$];
    logic [3:0] hist_q[$];
    bit rand_ready = 0;

    // Physical keypad: pressed switches connect the driven column to their rows.
    logic press_on = 1'b0;
    int press_col = 0;
    logic [3:0] press_mask = 4'b0000;
    assign rows = (press_on && cols[3-press_col]) ? press_mask : 4'b0000;

    // Keys by column, rows listed top to bottom.
    logic [3:0] keymap [4][4] = '{'{4'h1, 4'h4, 4'h7, 4'hE},
                                  '{4'h2, 4'h5, 4'h8, 4'h0},
                                  '{4'h3, 4'h6, 4'h9, 4'hF},
                                  '{4'hA, 4'hB, 4'hC, 4'hD}};
    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        int         col;
        logic [3:0] mask;
        logic [3:0] code;
        logic [6:0] segv;
    } vec_t;
    vec_t vecs[8];

    // Scoreboard: record every completed handshake.
    always @(posedge clk) begin
        if (reset_n && key_valid && key_ready) evq.push_back(key_code);
    end

    task automatic tick();
        @(negedge clk);
        if (rand_ready) key_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // Model: expected segments of digit i from the history of accepted keys.
    function automatic logic [6:0] exp_seg(int i);
        if (i < hist_q.size()) return segtab[hist_q[hist_q.size()-1-i]];
        return 7'h7F;
    endfunction

    function automatic logic [3:0] model_code(int c, logic [3:0] m);
        for (int b = 3; b >= 0; b--) if (m[b]) return keymap[c][3-b];
        return 4'h0;
    endfunction

    task automatic model_push(logic [3:0] code);
        hist_q.push_back(code);
        if (hist_q.size() > NDIGITS) void'(hist_q.pop_front());
    endtask

    task automatic press(int c, logic [3:0] m, int hold);
        press_col = c;
        press_mask = m;
        press_on = 1'b1;
        idle(hold);
        press_on = 1'b0;
    endtask

    task automatic check_digit(string name, int i, logic [6:0] exp);
        logic [NDIGITS-1:0] want;
        int n = 0;
        want = '0;
        want[i] = 1'b1;
        while (digit_en !== want && n < 200) begin
            tick();
            n++;
        end
        check({name, " digit_en"}, 32'(digit_en), 32'(want));
        check({name, " seg"}, 32'(seg), 32'(exp));
    endtask

    task automatic wait_cols(string name, logic [3:0] want);
        int n = 0;
        while (cols !== want && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(cols), 32'(want));
    endtask

    task automatic expect_one_event(string name, logic [3:0] code);
        check({name, " count"}, 32'(evq.size()), 1);
        if (evq.size() > 0) check({name, " code"}, 32'(evq[0]), 32'(code));
        evq.delete();
    endtask

    task automatic check_reset_outputs(string name);
        check({name, " cols"}, 32'(cols), 32'h8);
        check({name, " key_valid"}, 32'(key_valid), 0);
        check({name, " key_code"}, 32'(key_code), 0);
        check({name, " key_overflow"}, 32'(key_overflow), 0);
        check({name, " digit_en"}, 32'(digit_en), 1);
        check({name, " seg"}, 32'(seg), 32'h7F);
    endtask

    initial begin
        logic [3:0] expc;
        vecs[0] = '{0, 4'b1000, 4'h1, 7'h79};
        vecs[1] = '{0, 4'b0001, 4'hE, 7'h06};
        vecs[2] = '{1, 4'b0001, 4'h0, 7'h40};
        vecs[3] = '{3, 4'b0010, 4'hC, 7'h46};
        vecs[4] = '{2, 4'b0011, 4'h9, 7'h10};
        vecs[5] = '{0, 4'b0110, 4'h4, 7'h19};
        vecs[6] = '{3, 4'b1111, 4'hA, 7'h08};
        vecs[7] = '{2, 4'b0001, 4'hF, 7'h0E};

        // Reset, then idle scan with no keys.
        idle(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        for (int k = 0; k < 64; k++) begin
            expc = 4'b1000 >> ((k / 8) % 4);
            check($sformatf("idle cols k=%0d", k), 32'(cols), 32'(expc));
            if (k % 16 == 5) begin
                check("idle key_valid", 32'(key_valid), 0);
                check("idle seg", 32'(seg), 32'h7F);
            end
            tick();
        end

        // Key 5 held: one event, column frozen until the release is debounced.
        key_ready = 1'b1;
        press_col = 1;
        press_mask = 4'b0100;
        press_on = 1'b1;
        for (int n = 0; n < 200 && evq.size() == 0; n++) tick();
        idle(5);
        check("key5 frozen held", 32'(cols), 32'h4);
        press_on = 1'b0;
        idle(5);
        check("key5 frozen release", 32'(cols), 32'h4);
        idle(30);
        expect_one_event("key5", 4'h5);
        model_push(4'h5);
        check_digit("key5 d0", 0, 7'h12);
        check_digit("key5 d1", 1, 7'h7F);

        // Table of single and multi-row presses.
        for (int v = 0; v < 8; v++) begin
            press(vecs[v].col, vecs[v].mask, 80);
            idle(30);
            expect_one_event($sformatf("vec%0d", v), vecs[v].code);
            model_push(vecs[v].code);
            check_digit($sformatf("vec%0d d0", v), 0, vecs[v].segv);
            check_digit($sformatf("vec%0d d1", v), 1, exp_seg(1));
        end

        // Bouncing contact on column 3, top row: no event, then a clean press gives A.
        wait_cols("bounce col3", 4'b0001);
        press_col = 3;
        press_mask = 4'b1000;
        for (int t = 0; t < 10; t++) begin
            press_on = ~press_on;
            idle(3);
        end
        press_on = 1'b0;
        idle(20);
        check("bounce no event", 32'(evq.size()), 0);
        check("bounce key_valid", 32'(key_valid), 0);
        press(3, 4'b1000, 80);
        idle(30);
        expect_one_event("bounce stable", 4'hA);
        model_push(4'hA);
        check_digit("bounce d0", 0, 7'h08);

        // Consumer stalled: 3 is held in the buffer, 9 is dropped but still enters the history.
        key_ready = 1'b0;
        press(2, 4'b1000, 80);
        idle(30);
        press(2, 4'b0010, 80);
        idle(30);
        check("stall key_valid", 32'(key_valid), 1);
        check("stall key_code", 32'(key_code), 32'h3);
        check("stall overflow", 32'(key_overflow), 1);
        model_push(4'h3);
        model_push(4'h9);
        check_digit("stall d1", 1, 7'h30);
        check_digit("stall d0", 0, 7'h10);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("drain key_valid", 32'(key_valid), 0);
        expect_one_event("drain", 4'h3);
        check("overflow sticky", 32'(key_overflow), 1);

        // Short release glitch while debouncing the release: back to held, no second event.
        key_ready = 1'b1;
        press_col = 1;
        press_mask = 4'b0001;
        press_on = 1'b1;
        for (int n = 0; n < 200 && evq.size() == 0; n++) tick();
        idle(5);
        press_on = 1'b0;
        idle(4);
        press_on = 1'b1;
        idle(20);
        check("glitch cols frozen", 32'(cols), 32'h4);
        press_on = 1'b0;
        idle(30);
        expect_one_event("glitch", 4'h0);
        model_push(4'h0);

        // Reset in the middle of a press debounce.
        wait_cols("mid col3", 4'b0001);
        press_col = 2;
        press_mask = 4'b0001;
        press_on = 1'b1;
        wait_cols("mid col2", 4'b0010);
        idle(10);
        reset_n = 1'b0;
        press_on = 1'b0;
        tick();
        check_reset_outputs("mid reset");
        reset_n = 1'b1;
        hist_q.delete();
        idle(100);
        check("mid no event", 32'(evq.size()), 0);
        check("mid key_valid", 32'(key_valid), 0);
        check_digit("mid d0", 0, 7'h7F);
        check_digit("mid d1", 1, 7'h7F);

        // Random keys and row combinations with a randomly stalling consumer.
        rand_ready = 1;
        for (int it = 0; it < 16; it++) begin
            int c;
            logic [3:0] m;
            int n;
            c = $urandom_range(0, 3);
            m = 4'($urandom_range(1, 15));
            expc = model_code(c, m);
            press(c, m, $urandom_range(60, 90));
            idle($urandom_range(25, 40));
            n = 0;
            while (key_valid && n < 200) begin
                tick();
                n++;
            end
            check($sformatf("rand%0d drained", it), 32'(key_valid), 0);
            expect_one_event($sformatf("rand%0d", it), expc);
            model_push(expc);
            check_digit($sformatf("rand%0d d0", it), 0, exp_seg(0));
            check_digit($sformatf("rand%0d d1", it), 1, exp_seg(1));
        end
        rand_ready = 0;
        key_ready = 1'b0;
        check("rand overflow", 32'(key_overflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
